ram_responder: RTL

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/ram_responder.sv | 84 ++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types: the 32-bit word and the RAM handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage : cpu_types_pkg

// File: rtl/ram_responder.sv
// Word-addressed RAM model answering memory_control with a fixed BUSY latency
// before each ACCESS; malformed requests are flagged ERROR in the same cycle.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 256
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int unsigned CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] eff_cnt;
    word_t            cap_addr;
    logic             cap_write;
    word_t            mem [DEPTH];

    logic             req_any;
    logic             req_valid;
    logic             req_match;
    logic             access;
    logic [IDX_W-1:0] idx;

    // Classify the request, pick the handshake state and next latency count.
    // A request that differs from the captured one counts from zero, so its
    // first cycle is its first BUSY cycle.
    always_comb begin
        ramstate  = FREE;
        ramload   = '0;
        cnt_next  = '0;
        req_any   = ramREN | ramWEN;
        req_valid = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00)
                    && ((ramaddr >> 2) < 32'(DEPTH));
        req_match = (ramaddr == cap_addr) && (ramWEN == cap_write);
        eff_cnt   = req_match ? cnt : '0;
        idx       = ramaddr[IDX_W+1:2];
        access    = req_valid && (eff_cnt == CNT_W'(LAT));

        if (req_any && !req_valid) begin
            ramstate = ERROR;
        end else if (access) begin
            ramstate = ACCESS;
            if (ramREN) begin
                ramload = mem[idx];
            end
        end else if (req_valid) begin
            ramstate = BUSY;
            cnt_next = eff_cnt + CNT_W'(1);
        end
    end

    // Latency counter, captured request, and write commit at the end of ACCESS.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            cnt <= cnt_next;
            if (ramstate == BUSY) begin
                cap_addr  <= ramaddr;
                cap_write <= ramWEN;
            end
            if (access && ramWEN) begin
                mem[idx] <= ramstore;
            end
        end
    end

endmodule : ram_responder
